// File: rtl/mxint_exp_pkg.sv
// Shared constants, width helpers, per-element bundle type and the 2^r lookup
// for the MXINT exponential pipeline.
package mxint_exp_pkg;

  localparam int unsigned LOG2_E_MAN_DEF = 92;
  localparam int          LOG2_E_EXP_DEF = 1;
  localparam int          LOG2_E_W       = 8;   // log2(e) mantissa width, LOG2_E_W-1 frac bits
  localparam int          LUT_MAN_W      = 10;  // 2^r mantissa, 8 frac bits
  localparam int          N_W            = 4;   // per-element exponent n
  localparam int          R_FRAC_W       = 6;   // fractional bits of r

  function automatic int prod_w(input int man_w);
    return man_w + LOG2_E_W + 1;
  endfunction

  // Right shift that moves the product binary point to R_FRAC_W fraction bits at e1 = 0.
  function automatic int frac_shift(input int man_w, input int r_w);
    return (man_w - 1) + (LOG2_E_W - 1) - (r_w - 1);
  endfunction

  // Headroom for the largest possible left shift so nothing is lost before the clamp.
  function automatic int t_w(input int man_w, input int exp_w);
    return prod_w(man_w) + (1 << exp_w);
  endfunction

  typedef struct packed {
    logic [N_W-1:0]      n;
    logic [R_FRAC_W-1:0] r;
    logic                sat;
  } elem_t;

  // round(256 * 2^(i/64))
  localparam logic [LUT_MAN_W-1:0] P2_LUT [64] = '{
    10'd256, 10'd259, 10'd262, 10'd264, 10'd267, 10'd270, 10'd273, 10'd276,
    10'd279, 10'd282, 10'd285, 10'd288, 10'd292, 10'd295, 10'd298, 10'd301,
    10'd304, 10'd308, 10'd311, 10'd314, 10'd318, 10'd321, 10'd325, 10'd328,
    10'd332, 10'd336, 10'd339, 10'd343, 10'd347, 10'd350, 10'd354, 10'd358,
    10'd362, 10'd366, 10'd370, 10'd374, 10'd378, 10'd382, 10'd386, 10'd391,
    10'd395, 10'd399, 10'd403, 10'd408, 10'd412, 10'd417, 10'd421, 10'd426,
    10'd431, 10'd435, 10'd440, 10'd445, 10'd450, 10'd454, 10'd459, 10'd464,
    10'd470, 10'd475, 10'd480, 10'd485, 10'd490, 10'd496, 10'd501, 10'd506
  };

  function automatic logic [LUT_MAN_W-1:0] power2_lut(input logic [R_FRAC_W-1:0] r);
    return P2_LUT[r];
  endfunction

endpackage

// File: rtl/mxint_exp_lane.sv
// One element of the MXINT exp pipeline: multiply by log2(e), align and split
// into n / r with clamping, then map r through the 2^r table.
module mxint_exp_lane
  import mxint_exp_pkg::*;
#(
  parameter int unsigned IN_MAN_W  = 8,
  parameter int unsigned IN_EXP_W  = 3,
  parameter int unsigned OUT_MAN_W = LUT_MAN_W,
  parameter int unsigned OUT_EXP_W = N_W,
  parameter int unsigned R_W       = R_FRAC_W + 1,
  parameter int unsigned LOG2E_MAN = LOG2_E_MAN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_MAN_W-1:0]  man,
  input  logic [IN_EXP_W:0]    e1,    // already S1-registered, aligned with prod_q
  output logic [OUT_MAN_W-1:0] mant,
  output logic [OUT_EXP_W-1:0] n,
  output logic                 sat
);

  localparam int PW      = prod_w(IN_MAN_W);
  localparam int TW      = t_w(IN_MAN_W, IN_EXP_W);
  localparam int SH_BASE = frac_shift(IN_MAN_W, R_W);

  localparam logic signed [LOG2_E_W:0] K     = (LOG2_E_W + 1)'(LOG2E_MAN);
  localparam logic signed [TW-1:0]     N_MAX = TW'((1 << (OUT_EXP_W - 1)) - 1);
  localparam logic signed [TW-1:0]     N_MIN = ~N_MAX;

  logic signed [PW-1:0] prod_q;
  logic signed [TW-1:0] t_ext, t, fl;
  int                   shamt;
  elem_t                s2_d, s2_q;

  always_ff @(posedge clk) begin
    if (en) prod_q <= PW'($signed(man)) * PW'(K);
  end

  always_comb begin
    t_ext = TW'(prod_q);
    shamt = SH_BASE - int'($signed(e1));
    if (shamt >= 0) t = t_ext >>> shamt;
    else            t = t_ext <<< (-shamt);
    fl       = t >>> (R_W - 1);
    s2_d.n   = fl[OUT_EXP_W-1:0];
    s2_d.r   = t[R_W-2:0];
    s2_d.sat = 1'b0;
    if (fl > N_MAX) begin
      s2_d.n   = N_MAX[OUT_EXP_W-1:0];
      s2_d.r   = '1;
      s2_d.sat = 1'b1;
    end else if (fl < N_MIN) begin
      s2_d.n   = N_MIN[OUT_EXP_W-1:0];
      s2_d.r   = '0;
      s2_d.sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) s2_q <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mant <= '0;
      n    <= '0;
      sat  <= 1'b0;
    end else if (en) begin
      mant <= power2_lut(s2_q.r);
      n    <= s2_q.n;
      sat  <= s2_q.sat;
    end
  end

endmodule

// File: rtl/mxint_exp_pipe.sv
// Three-stage back-pressurable MXINT exp: y = 2^n * 2^r per element of a block.
// Owns the shared exponent add, the valid chain and the global stall enable.
module mxint_exp_pipe
  import mxint_exp_pkg::*;
#(
  parameter int unsigned DATA_IN_MAN_WIDTH  = 8,
  parameter int unsigned DATA_IN_EXP_WIDTH  = 3,
  parameter int unsigned BLOCK_SIZE         = 16,
  parameter int unsigned DATA_OUT_MAN_WIDTH = LUT_MAN_W,
  parameter int unsigned DATA_OUT_EXP_WIDTH = N_W,
  parameter int unsigned DATA_R_WIDTH       = R_FRAC_W + 1,
  parameter int unsigned LOG2_E_MAN         = LOG2_E_MAN_DEF,
  parameter int          LOG2_E_EXP         = LOG2_E_EXP_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_IN_MAN_WIDTH*BLOCK_SIZE-1:0]  mdata_in_0,
  input  logic [DATA_IN_EXP_WIDTH-1:0]             edata_in_0,
  input  logic                                     data_in_0_valid,
  output logic                                     data_in_0_ready,
  output logic [DATA_OUT_MAN_WIDTH*BLOCK_SIZE-1:0] mdata_out_0,
  output logic [DATA_OUT_EXP_WIDTH*BLOCK_SIZE-1:0] edata_out_0,
  output logic [BLOCK_SIZE-1:0]                    sat_out_0,
  output logic                                     data_out_0_valid,
  input  logic                                     data_out_0_ready
);

  logic                       en;
  logic [2:0]                 vld_q;
  logic [DATA_IN_EXP_WIDTH:0] e1_q;

  // Whole pipe advances together; bubbles only collapse at the output.
  assign en               = ~data_out_0_valid | data_out_0_ready;
  assign data_in_0_ready  = en;
  assign data_out_0_valid = vld_q[2];

  always_ff @(posedge clk) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= {vld_q[1:0], data_in_0_valid};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      e1_q <= {edata_in_0[DATA_IN_EXP_WIDTH-1], edata_in_0}
            + (DATA_IN_EXP_WIDTH + 1)'(LOG2_E_EXP);
    end
  end

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    mxint_exp_lane #(
      .IN_MAN_W  (DATA_IN_MAN_WIDTH),
      .IN_EXP_W  (DATA_IN_EXP_WIDTH),
      .OUT_MAN_W (DATA_OUT_MAN_WIDTH),
      .OUT_EXP_W (DATA_OUT_EXP_WIDTH),
      .R_W       (DATA_R_WIDTH),
      .LOG2E_MAN (LOG2_E_MAN)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .man  (mdata_in_0[i*DATA_IN_MAN_WIDTH +: DATA_IN_MAN_WIDTH]),
      .e1   (e1_q),
      .mant (mdata_out_0[i*DATA_OUT_MAN_WIDTH +: DATA_OUT_MAN_WIDTH]),
      .n    (edata_out_0[i*DATA_OUT_EXP_WIDTH +: DATA_OUT_EXP_WIDTH]),
      .sat  (sat_out_0[i])
    );
  end

endmodule

// File: tb/tb_mxint_exp_pipe.sv
// Self-checking bench for mxint_exp_pipe: directed points, scoreboarded streams
// under random back-pressure, and reset with beats in flight.
module tb_mxint_exp_pipe;

  localparam int BS = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [8*BS-1:0]  mdata_in_0 = '0;
  logic [2:0]       edata_in_0 = '0;
  logic             data_in_0_valid = 1'b0;
  logic             data_in_0_ready;
  logic [10*BS-1:0] mdata_out_0;
  logic [4*BS-1:0]  edata_out_0;
  logic [BS-1:0]    sat_out_0;
  logic             data_out_0_valid;
  logic             data_out_0_ready = 1'b0;

  typedef struct packed {
    logic [4*BS-1:0] n;
    logic [6*BS-1:0] r;
    logic [BS-1:0]   sat;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;

  mxint_exp_pipe dut (
    .clk              (clk),
    .rst              (rst),
    .mdata_in_0       (mdata_in_0),
    .edata_in_0       (edata_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .mdata_out_0      (mdata_out_0),
    .edata_out_0      (edata_out_0),
    .sat_out_0        (sat_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  always #5 clk = ~clk;

  // Reference in real arithmetic: x = man/128 * 2^exp, t = floor(64 * x * 1.4375).
  function automatic void model_elem(input int man, input int ex,
                                     output int n, output int r, output int sat);
    real x, t;
    int  ti, fl;
    x  = real'(man) / 128.0 * (2.0 ** real'(ex));
    t  = $floor(x * 1.4375 * 64.0);
    ti = $rtoi(t);
    fl = $rtoi($floor(t / 64.0));
    if (fl > 7) begin
      n = 7; r = 63; sat = 1;
    end else if (fl < -8) begin
      n = -8; r = 0; sat = 1;
    end else begin
      n = fl; r = ti - fl * 64; sat = 0;
    end
  endfunction

  function automatic beat_t model_beat(input logic [8*BS-1:0] m, input logic [2:0] e);
    beat_t b;
    int    n, r, s;
    for (int k = 0; k < BS; k++) begin
      model_elem(int'($signed(m[k*8 +: 8])), int'($signed(e)), n, r, s);
      b.n[k*4 +: 4] = 4'(n);
      b.r[k*6 +: 6] = 6'(r);
      b.sat[k]      = s[0];
    end
    return b;
  endfunction

  function automatic int mant_ref(input int r);
    return $rtoi(256.0 * (2.0 ** (real'(r) / 64.0)) + 0.5);
  endfunction

  // Number of lanes whose mantissa is more than 1 LSB from round(256*2^(r/64)).
  function automatic int mant_bad(input logic [10*BS-1:0] act, input logic [6*BS-1:0] r);
    int bad = 0;
    int d;
    for (int k = 0; k < BS; k++) begin
      d = int'(act[k*10 +: 10]) - mant_ref(int'(r[k*6 +: 6]));
      if (d > 1 || d < -1) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_out_0_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", data_out_0_valid);
    end
    checks++;
    if ({mdata_out_0, edata_out_0, sat_out_0} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got m=%h e=%h s=%h exp=0", mdata_out_0, edata_out_0, sat_out_0);
    end
    checks++;
    if (data_in_0_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", data_in_0_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_points();
    logic [7:0] pm [5] = '{8'd0, 8'd64, 8'hc0, 8'd127, 8'h80};
    logic [2:0] pe [5] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3};
    logic [3:0] pn [5] = '{4'd0, 4'd1, 4'he, 4'd7, 4'h8};
    int         pv [5] = '{256, 347, 378, 506, 256};
    logic       ps [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int         lat, bad, d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_out_0_ready = 1'b1;
      mdata_in_0       = {BS{pm[i]}};
      edata_in_0       = pe[i];
      data_in_0_valid  = 1'b1;
      @(posedge clk);
      #1;
      data_in_0_valid = 1'b0;
      lat = 1;
      while (!data_out_0_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != 3) begin
        failures++;
        $display("FAIL point%0d_latency got=%0d exp=3", i, lat);
      end
      checks++;
      if (edata_out_0 !== {BS{pn[i]}}) begin
        failures++;
        $display("FAIL point%0d_n got=%h exp=%h", i, edata_out_0, {BS{pn[i]}});
      end
      checks++;
      if (sat_out_0 !== {BS{ps[i]}}) begin
        failures++;
        $display("FAIL point%0d_sat got=%h exp=%h", i, sat_out_0, {BS{ps[i]}});
      end
      bad = 0;
      for (int k = 0; k < BS; k++) begin
        d = int'(mdata_out_0[k*10 +: 10]) - pv[i];
        if (d > 1 || d < -1) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL point%0d_mant got lane0=%0d exp=%0d (+-1), bad lanes=%0d",
                 i, mdata_out_0[9:0], pv[i], bad);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stream(input int nbeats, input int ready_pct, input bit gaps);
    sb.delete();
    fork
      begin : driver
        logic [8*BS-1:0] m;
        logic [2:0]      e;
        int              w;
        for (int i = 0; i < nbeats; i++) begin
          if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            data_in_0_valid = 1'b0;
          end
          @(negedge clk);
          m = {$urandom, $urandom, $urandom, $urandom};
          e = 3'($urandom_range(0, 7));
          mdata_in_0      = m;
          edata_in_0      = e;
          data_in_0_valid = 1'b1;
          #1;
          w = 0;
          while (!data_in_0_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
          end
          if (w >= 200) begin
            checks++;
            failures++;
            $display("FAIL stream_accept_timeout got=ready0 exp=ready1 beat=%0d", i);
            break;
          end
          @(posedge clk);
          sb.push_back(model_beat(m, e));
        end
        @(negedge clk);
        data_in_0_valid = 1'b0;
      end
      begin : consumer
        int     popped = 0;
        int     cyc = 0;
        bit     stalled = 1'b0;
        logic [10*BS+4*BS+BS:0] held = '0;
        beat_t  x;
        while (popped < nbeats && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (stalled) begin
            checks++;
            if ({mdata_out_0, edata_out_0, sat_out_0, data_out_0_valid} !== held) begin
              failures++;
              $display("FAIL stream_hold got=%h exp=%h",
                       {mdata_out_0, edata_out_0, sat_out_0, data_out_0_valid}, held);
            end
          end
          data_out_0_ready = ($urandom_range(0, 99) < ready_pct);
          stalled = data_out_0_valid && !data_out_0_ready;
          held    = {mdata_out_0, edata_out_0, sat_out_0, data_out_0_valid};
          if (data_out_0_valid && data_out_0_ready) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL stream_extra_beat got=valid exp=no beat");
            end else begin
              x = sb.pop_front();
              checks++;
              if (edata_out_0 !== x.n) begin
                failures++;
                $display("FAIL stream_n beat=%0d got=%h exp=%h", popped, edata_out_0, x.n);
              end
              checks++;
              if (sat_out_0 !== x.sat) begin
                failures++;
                $display("FAIL stream_sat beat=%0d got=%h exp=%h", popped, sat_out_0, x.sat);
              end
              checks++;
              if (mant_bad(mdata_out_0, x.r) != 0) begin
                failures++;
                $display("FAIL stream_mant beat=%0d got=%h r=%h", popped, mdata_out_0, x.r);
              end
              popped++;
            end
          end
        end
        checks++;
        if (popped != nbeats) begin
          failures++;
          $display("FAIL stream_count got=%0d exp=%0d", popped, nbeats);
        end
        if (ready_pct == 100 && !gaps) begin
          checks++;
          if (cyc > nbeats + 4) begin
            failures++;
            $display("FAIL back_to_back_cycles got=%0d exp<=%0d", cyc, nbeats + 4);
          end
        end
      end
    join
    data_out_0_ready = 1'b1;
    checks++;
    begin
      int ghosts = 0;
      repeat (5) begin
        @(negedge clk);
        if (data_out_0_valid) ghosts++;
      end
      if (ghosts != 0) begin
        failures++;
        $display("FAIL stream_duplicate got=%0d extra beats exp=0", ghosts);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [8*BS-1:0] m;
    logic [2:0]      e;
    beat_t           x;
    int              lat, ghosts;
    sb.delete();
    data_out_0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mdata_in_0      = {$urandom, $urandom, $urandom, $urandom};
      edata_in_0      = 3'($urandom_range(0, 7));
      data_in_0_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    data_in_0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_out_0_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_valid got=%b exp=0", data_out_0_valid);
    end
    checks++;
    if ({mdata_out_0, edata_out_0, sat_out_0} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got m=%h e=%h s=%h exp=0", mdata_out_0, edata_out_0, sat_out_0);
    end
    @(negedge clk);
    rst = 1'b0;
    ghosts = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_out_0_valid) ghosts++;
    end
    checks++;
    if (ghosts != 0) begin
      failures++;
      $display("FAIL midreset_ghost got=%0d beats exp=0", ghosts);
    end
    m = {$urandom, $urandom, $urandom, $urandom};
    e = 3'($urandom_range(0, 7));
    x = model_beat(m, e);
    mdata_in_0      = m;
    edata_in_0      = e;
    data_in_0_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
    lat = 1;
    while (!data_out_0_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL midreset_latency got=%0d exp=3", lat);
    end
    checks++;
    if (edata_out_0 !== x.n || sat_out_0 !== x.sat) begin
      failures++;
      $display("FAIL midreset_beat got n=%h s=%h exp n=%h s=%h", edata_out_0, sat_out_0, x.n, x.sat);
    end
    checks++;
    if (mant_bad(mdata_out_0, x.r) != 0) begin
      failures++;
      $display("FAIL midreset_mant got=%h r=%h", mdata_out_0, x.r);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_points();
    test_stream(20, 50, 1'b1);
    test_stream(12, 100, 1'b0);
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
